// File: rtl/line_buffer_nk_if.sv
// Pixel stream bundle for line_buffer_nk: raster input side and column-tap output side.
interface line_buffer_nk_if #(
  parameter int KERNEL_SIZE = 3,
  parameter int PIXEL_WIDTH = 16
);
  logic [10:0]                             hcount_in;
  logic [9:0]                              vcount_in;
  logic [PIXEL_WIDTH-1:0]                  pixel_data_in;
  logic                                    data_valid_in;
  logic [KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0] line_buffer_out;
  logic [10:0]                             hcount_out;
  logic [9:0]                              vcount_out;
  logic                                    data_valid_out;

  modport master (
    output hcount_in, vcount_in, pixel_data_in, data_valid_in,
    input  line_buffer_out, hcount_out, vcount_out, data_valid_out
  );

  modport slave (
    input  hcount_in, vcount_in, pixel_data_in, data_valid_in,
    output line_buffer_out, hcount_out, vcount_out, data_valid_out
  );
endinterface

// File: rtl/line_buffer_nk.sv
// Streaming line buffer: KERNEL_SIZE+1 row memories, one vertical column of taps per pixel, 2-cycle latency.
// Optional vertical border clamping enabled by defining LB_EDGE_REPLICATE_EN.
module line_buffer_nk #(
  parameter int HRES        = 1280,
  parameter int VRES        = 720,
  parameter int KERNEL_SIZE = 3,
  parameter int PIXEL_WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  line_buffer_nk_if.slave  bus
);

  localparam int H     = (KERNEL_SIZE - 1) / 2;
  localparam int NROWS = KERNEL_SIZE + 1;
  localparam int RW    = $clog2(NROWS);
  localparam int AW    = (HRES > 1) ? $clog2(HRES) : 1;

  localparam logic [RW-1:0] LAST_ROW = RW'(KERNEL_SIZE);
  localparam logic [10:0]   LAST_COL = 11'(HRES - 1);
  localparam logic [9:0]    V_SHIFT  = 10'(H + 1);
  localparam logic [9:0]    V_WRAP   = 10'(VRES - H - 1);

  logic [PIXEL_WIDTH-1:0]                  mem [NROWS][HRES];
  logic [PIXEL_WIDTH-1:0]                  rd_data [NROWS];
  logic [PIXEL_WIDTH-1:0]                  raw_tap [KERNEL_SIZE];
  logic [KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0] tap_next;
  logic [RW-1:0]                           wr_row;
  logic [RW-1:0]                           wr_row_d1;
  logic [10:0]                             hcount_d1;
  logic [9:0]                              vcount_d1;
  logic                                    valid_d1;
  logic [9:0]                              vcount_next;
  logic [AW-1:0]                           addr;
  logic                                    end_of_line;

  assign addr        = bus.hcount_in[AW-1:0];
  assign end_of_line = bus.data_valid_in && (bus.hcount_in == LAST_COL);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_row <= '0;
    end else if (end_of_line) begin
      wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
    end
  end

  // Port A: memory contents survive reset; only writes are blocked while it is held.
  always_ff @(posedge clk_in) begin
    if (bus.data_valid_in && !rst_in) begin
      mem[wr_row][addr] <= bus.pixel_data_in;
    end
  end

  // Port B: every row read at the incoming column, registered.
  always_ff @(posedge clk_in) begin
    for (int r = 0; r < NROWS; r++) begin
      if (rst_in) rd_data[r] <= '0;
      else        rd_data[r] <= mem[r][addr];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_row_d1 <= '0;
      hcount_d1 <= '0;
      vcount_d1 <= '0;
      valid_d1  <= 1'b0;
    end else begin
      wr_row_d1 <= wr_row;
      hcount_d1 <= bus.hcount_in;
      vcount_d1 <= bus.vcount_in;
      valid_d1  <= bus.data_valid_in;
    end
  end

  // Oldest row sits just after the row being written; the written row itself is never a tap.
  for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_tap
    localparam logic [RW:0] OFFSET = (RW+1)'(k + 1);
    logic [RW:0]   sum;
    logic [RW-1:0] src;
    assign sum        = {1'b0, wr_row_d1} + OFFSET;
    assign src        = (sum > {1'b0, LAST_ROW}) ? RW'(sum - (RW+1)'(NROWS)) : RW'(sum);
    assign raw_tap[k] = rd_data[src];
  end

  assign vcount_next = (vcount_d1 >= V_SHIFT) ? vcount_d1 - V_SHIFT : vcount_d1 + V_WRAP;

`ifdef LB_EDGE_REPLICATE_EN
  logic [PIXEL_WIDTH-1:0] top_tap;
  logic [PIXEL_WIDTH-1:0] bot_tap;

  // Taps reaching past the frame borders repeat the tap holding row 0 or row VRES-1.
  always_comb begin
    int c;
    int row;
    c        = int'(vcount_next);
    row      = 0;
    top_tap  = raw_tap[0];
    bot_tap  = raw_tap[KERNEL_SIZE-1];
    tap_next = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      if (c - H + k == 0)        top_tap = raw_tap[k];
      if (c - H + k == VRES - 1) bot_tap = raw_tap[k];
    end
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      row = c - H + k;
      if (row < 0)             tap_next[k] = top_tap;
      else if (row > VRES - 1) tap_next[k] = bot_tap;
      else                     tap_next[k] = raw_tap[k];
    end
  end
`else
  always_comb begin
    tap_next = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      tap_next[k] = raw_tap[k];
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.line_buffer_out <= '0;
      bus.hcount_out      <= '0;
      bus.vcount_out      <= '0;
      bus.data_valid_out  <= 1'b0;
    end else begin
      bus.line_buffer_out <= tap_next;
      bus.hcount_out      <= hcount_d1;
      bus.vcount_out      <= vcount_next;
      bus.data_valid_out  <= valid_d1;
    end
  end

endmodule

// File: tb/tb_line_buffer_nk.sv
// Bench for line_buffer_nk: two instances (3-tap/6-line and 5-tap/10-line, 8 pixels per line)
// fed raster streams, checked against an image-row model of which frame row each tap should hold.
module tb_line_buffer_nk;

  localparam int HR = 8;

  typedef struct {
    bit rst;
    bit vld;
    int v;
    int h;
    int lines;
  } rec_t;

  bit   clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  line_buffer_nk_if #(.KERNEL_SIZE(3), .PIXEL_WIDTH(16)) b3 ();
  line_buffer_nk_if #(.KERNEL_SIZE(5), .PIXEL_WIDTH(16)) b5 ();

  line_buffer_nk #(.HRES(HR), .VRES(6), .KERNEL_SIZE(3), .PIXEL_WIDTH(16)) dut3 (
    .clk_in(clk), .rst_in(rst), .bus(b3)
  );
  line_buffer_nk #(.HRES(HR), .VRES(10), .KERNEL_SIZE(5), .PIXEL_WIDTH(16)) dut5 (
    .clk_in(clk), .rst_in(rst), .bus(b5)
  );

  rec_t p1 [2];
  rec_t p2 [2];
  int   sv [2];
  int   sh [2];
  int   sl [2];
  int   kk [2] = '{3, 5};
  int   vr [2] = '{6, 10};
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input int s, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s stream%0d: observed %h expected %h", tag, s, obs, exp);
    end
  endtask

  // Fixed expectations for the landmark pixels of each stream.
  task automatic spot(input int s, input rec_t b, input logic [111:0] flat, input logic [9:0] ovc);
    logic [15:0] e [5];
    int   n;
    int   evc;
    n   = 0;
    evc = 0;
    e   = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    if (s == 0 && b.lines >= 3 && b.v == 3 && b.h == 5) begin
      n = 3; evc = 1; e[0] = 16'h0005; e[1] = 16'h0105; e[2] = 16'h0205;
    end
    if (s == 0 && b.lines >= 3 && b.v == 2 && b.h == 2) begin
      n = 3; evc = 0; e[1] = 16'h0002; e[2] = 16'h0102;
`ifdef LB_EDGE_REPLICATE_EN
      e[0] = 16'h0002;
`else
      e[0] = 16'h0502;
`endif
    end
    if (s == 0 && b.lines >= 3 && b.v == 1 && b.h == 7) begin
      n = 3; evc = 5; e[0] = 16'h0407; e[1] = 16'h0507;
`ifdef LB_EDGE_REPLICATE_EN
      e[2] = 16'h0507;
`else
      e[2] = 16'h0007;
`endif
    end
    if (s == 1 && b.lines >= 5 && b.v == 7 && b.h == 0) begin
      n = 5; evc = 4;
      e[0] = 16'h0200; e[1] = 16'h0300; e[2] = 16'h0400; e[3] = 16'h0500; e[4] = 16'h0600;
    end
    if (n > 0) begin
      chk("spot_vcount", s, 32'(ovc), 32'(evc));
      for (int k = 0; k < n; k++) chk($sformatf("spot_tap%0d", k), s, 32'(flat[k*16 +: 16]), 32'(e[k]));
    end
  endtask

  task automatic check(input int s);
    rec_t           a, b;
    logic           ov;
    logic [10:0]    oh;
    logic [9:0]     ovc;
    logic [111:0]   flat;
    int             kn, vres, hh, c, r, d, row;
    logic [15:0]    ep;
    a = p1[s]; b = p2[s]; kn = kk[s]; vres = vr[s]; hh = (kn - 1) / 2;
    if (s == 0) begin
      ov = b3.data_valid_out; oh = b3.hcount_out; ovc = b3.vcount_out; flat = 112'(b3.line_buffer_out);
    end else begin
      ov = b5.data_valid_out; oh = b5.hcount_out; ovc = b5.vcount_out; flat = 112'(b5.line_buffer_out);
    end
    if (a.rst) begin
      chk("rst_valid", s, 32'(ov), 32'd0);
      chk("rst_hcount", s, 32'(oh), 32'd0);
      chk("rst_vcount", s, 32'(ovc), 32'd0);
      for (int k = 0; k < kn; k++) chk($sformatf("rst_tap%0d", k), s, 32'(flat[k*16 +: 16]), 32'd0);
    end else if (b.rst) begin
      chk("post_rst_valid", s, 32'(ov), 32'd0);
      chk("post_rst_hcount", s, 32'(oh), 32'd0);
    end else begin
      c = b.v - (hh + 1);
      if (c < 0) c += vres;
      chk("valid", s, 32'(ov), 32'(b.vld));
      chk("hcount", s, 32'(oh), 32'(b.h));
      chk("vcount", s, 32'(ovc), 32'(c));
      if (b.vld) begin
        for (int k = 0; k < kn; k++) begin
          r = c - hh + k;
`ifdef LB_EDGE_REPLICATE_EN
          if (r < 0) r = 0;
          if (r > vres - 1) r = vres - 1;
`endif
          d   = hh + 1 + c - r;
          row = ((r % vres) + vres) % vres;
          ep  = {row[7:0], b.h[7:0]};
          if (d <= b.lines) chk($sformatf("tap%0d", k), s, 32'(flat[k*16 +: 16]), 32'(ep));
        end
        spot(s, b, flat, ovc);
      end
    end
  endtask

  task automatic cycle(input bit r, input bit vld);
    rec_t        n;
    logic [15:0] pix;
    int          vv;
    @(negedge clk);
    check(0);
    check(1);
    rst = r;
    for (int s = 0; s < 2; s++) begin
      vv      = sv[s];
      n.rst   = r;
      n.vld   = vld;
      n.v     = vv;
      n.lines = sl[s];
      n.h     = vld ? sh[s] : int'($urandom_range(0, HR - 1));
      pix     = vld ? {vv[7:0], n.h[7:0]} : 16'($urandom);
      if (s == 0) begin
        b3.hcount_in = 11'(n.h); b3.vcount_in = 10'(vv); b3.pixel_data_in = pix; b3.data_valid_in = vld;
      end else begin
        b5.hcount_in = 11'(n.h); b5.vcount_in = 10'(vv); b5.pixel_data_in = pix; b5.data_valid_in = vld;
      end
      p2[s] = p1[s];
      p1[s] = n;
      if (r) begin
        sl[s] = 0;
      end else if (vld) begin
        if (sh[s] == HR - 1) begin
          sh[s] = 0;
          sv[s] = (sv[s] + 1) % vr[s];
          sl[s]++;
        end else begin
          sh[s]++;
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      p1[s] = '{rst: 1'b1, vld: 1'b0, v: 0, h: 0, lines: 0};
      p2[s] = '{rst: 1'b1, vld: 1'b0, v: 0, h: 0, lines: 0};
      sv[s] = 0; sh[s] = 0; sl[s] = 0;
    end
    b3.hcount_in = '0; b3.vcount_in = '0; b3.pixel_data_in = '0; b3.data_valid_in = 1'b0;
    b5.hcount_in = '0; b5.vcount_in = '0; b5.pixel_data_in = '0; b5.data_valid_in = 1'b0;

    repeat (3) cycle(1'b1, 1'b0);
    // Two full 6-line frames plus the start of a third, ending at (v=2, h=4).
    repeat (116) cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b1, 1'b1);
    for (int s = 0; s < 2; s++) begin
      sv[s] = 0; sh[s] = 0;
    end
    repeat (400) cycle(1'b0, $urandom_range(0, 99) >= 30);
    repeat (4) cycle(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
